vadd_seq: RTL and testbench
===========================

# vadd_seq

Command sequencer for the vector add/min/max/compare/average datapath. It accepts one vector instruction at a time and breaks it into 64-bit beats. For each beat it issues source reads to the vector register file and drives the datapath's per-beat sideband (sew, opSel, destination address, byte enables, mask start index, request start/end, average flag) aligned to the register-file read latency. It signals completion once the non-stallable datapath pipeline has drained.

## Interface
- DATA_WIDTH, 64, datapath beat width in bits.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 32, register-file beat address width.
- VL_WIDTH, 11, element-count width.
- OPSEL_WIDTH, 9, opSel width.
- RD_LAT, 2, register-file read latency in cycles (≥1).
- DP_LAT, 6, datapath in_valid→out_valid latency.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_opSel  in  OPSEL_WIDTH  datapath operation select.
- cmd_sew  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- cmd_vl  in  VL_WIDTH  element count.
- cmd_avg  in  1  averaging (fixed-point) op.
- cmd_vs0, cmd_vs1, cmd_vd  in  ADDR_WIDTH each  base beat addresses.
- rd_valid  out  1  register-file read strobe.
- rd_addr0, rd_addr1  out  ADDR_WIDTH each  source beat addresses.
- dp_valid, dp_sew, dp_opSel, dp_addr, dp_start_idx[5:0], dp_req_start, dp_req_end, dp_be, dp_avg  out  datapath sideband.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE
  - cmd_ready=1.
  - On cmd_valid, latch the command.
  - vl=0: go to DRAIN with drain count 0, so done pulses next cycle and no beats are issued.
  - Otherwise go to ISSUE.
- ISSUE
  - One beat per cycle, no stalls.
  - epb (elements per beat) = 8>>sew.
  - Beat b: rd_addr0=vs0+b, rd_addr1=vs1+b, elem_idx=b·epb.
  - Remaining elements rem = vl−elem_idx.
  - be = all ones if rem≥epb; otherwise low (rem<<sew) bits set.
  - req_start=1 on beat 0; req_end=1 on the last beat (rem≤epb).
  - After the last beat, load drain=RD_LAT+DP_LAT and go to DRAIN.
- DRAIN
  - Decrement drain each cycle.
  - At 0: done=1 for one cycle, go to IDLE.
- Non-mask ops (opSel[8]=0): dp_addr=vd+b, dp_start_idx=0.
- busy=1 in ISSUE and DRAIN.
- cmd_valid in a non-IDLE state is ignored: not accepted, no side effect.
- Arithmetic:
  - Beat counter and elem_idx are VL_WIDTH bits.
  - Address adds wrap modulo 2^ADDR_WIDTH.
  - be computed from rem in BE_WIDTH+1 bits before truncation.

## Timing
- Command accepted cycle t → first rd_valid at t+1.
- Sideband from issue cycle c appears on dp_* at c+RD_LAT, through a fixed shift register.
- Last issue at cycle L → done at L+RD_LAT+DP_LAT+1.
- cmd_ready rises in the cycle after done.
- All dp_* fields are zero when dp_valid=0.
- Reset values: cmd_ready=1 on the first cycle after rst deasserts. rd_valid, rd_addr*, all dp_*, busy, done are all 0. FSM state is IDLE and the delay line is cleared.
- Reset mid-command: all in-flight sideband is discarded, no done pulse, return to IDLE.

## Configuration
- VADD_SEQ_MASK_EN defined:
  - Mask ops (opSel[8]=1) get dp_start_idx=elem_idx[5:0].
  - dp_addr=vd+(elem_idx>>6).
- VADD_SEQ_MASK_EN undefined:
  - opSel[8] is forced to 0 on dp_opSel.
  - dp_start_idx is tied to 0.
  - All ops use dp_addr=vd+b.

## Structure
- Package vadd_seq_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN);
  - default latency constants (RD_LAT, DP_LAT);
  - the function computing be from rem and sew.
- Sub-module vadd_seq_dly: parameterised RD_LAT-deep sideband delay line with asynchronous active-low clear.

## Test plan
- sew=0, vl=16, vs0=0x10, vs1=0x20, vd=0x30 → 2 beats, rd_addr0=0x10/0x11, be=0xFF both, req_start on beat 0, req_end on beat 1, done at L+9 with defaults.
- sew=2, vl=5 → 3 beats, last be=0x0F, dp_addr=vd..vd+2.
- vl=0 → no rd_valid, done one cycle after accept, cmd_ready back the next cycle.
- With VADD_SEQ_MASK_EN, opSel[8]=1, sew=0, vl=72 → 9 beats, dp_start_idx=0,8,…,56,0, dp_addr increments at beat 8. Without the macro: dp_start_idx all 0, dp_opSel[8]=0.
- cmd_valid held high during ISSUE → second command accepted only after done. Back-to-back commands: no overlap, no dropped beats.
- rst asserted during ISSUE with beats still in the delay line → dp_valid=0 at once, no done, cmd_ready=1 after release.

Source files
------------

// File: rtl/vadd_seq_pkg.sv
// Shared types, widths and helpers for the vadd_seq command sequencer.
package vadd_seq_pkg;

    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned VL_WIDTH    = 11;
    localparam int unsigned OPSEL_WIDTH = 9;
    localparam int unsigned SIDX_WIDTH  = 6;
    localparam int unsigned DEF_RD_LAT  = 2;
    localparam int unsigned DEF_DP_LAT  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPSEL_WIDTH-1:0] opsel;
        logic [1:0]             sew;
        logic [VL_WIDTH-1:0]    vl;
        logic                   avg;
        logic [ADDR_WIDTH-1:0]  vs0;
        logic [ADDR_WIDTH-1:0]  vs1;
        logic [ADDR_WIDTH-1:0]  vd;
    } cmd_t;

    typedef struct packed {
        logic                   valid;
        logic [1:0]             sew;
        logic [OPSEL_WIDTH-1:0] opsel;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [SIDX_WIDTH-1:0]  start_idx;
        logic                   req_start;
        logic                   req_end;
        logic [BE_WIDTH-1:0]    be;
        logic                   avg;
    } sb_t;

    // Byte enables for a beat with rem elements left; full beat once rem covers it.
    function automatic logic [BE_WIDTH-1:0] be_calc(input logic [VL_WIDTH-1:0] rem,
                                                    input logic [1:0]          sew);
        logic [VL_WIDTH-1:0] epb;
        logic [BE_WIDTH:0]   nbytes;
        logic [BE_WIDTH:0]   mask;
        epb = VL_WIDTH'(BE_WIDTH) >> sew;
        if (rem >= epb) begin
            be_calc = '1;
        end else begin
            nbytes  = (BE_WIDTH+1)'(rem) << sew;
            mask    = ((BE_WIDTH+1)'(1) << nbytes) - (BE_WIDTH+1)'(1);
            be_calc = BE_WIDTH'(mask);
        end
    endfunction

endpackage

// File: rtl/vadd_seq_if.sv
// Command, register-file read and datapath sideband bundle of the sequencer.
interface vadd_seq_if;
    import vadd_seq_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OPSEL_WIDTH-1:0] cmd_opSel;
    logic [1:0]             cmd_sew;
    logic [VL_WIDTH-1:0]    cmd_vl;
    logic                   cmd_avg;
    logic [ADDR_WIDTH-1:0]  cmd_vs0;
    logic [ADDR_WIDTH-1:0]  cmd_vs1;
    logic [ADDR_WIDTH-1:0]  cmd_vd;
    logic                   rd_valid;
    logic [ADDR_WIDTH-1:0]  rd_addr0;
    logic [ADDR_WIDTH-1:0]  rd_addr1;
    logic                   dp_valid;
    logic [1:0]             dp_sew;
    logic [OPSEL_WIDTH-1:0] dp_opSel;
    logic [ADDR_WIDTH-1:0]  dp_addr;
    logic [SIDX_WIDTH-1:0]  dp_start_idx;
    logic                   dp_req_start;
    logic                   dp_req_end;
    logic [BE_WIDTH-1:0]    dp_be;
    logic                   dp_avg;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_valid, cmd_opSel, cmd_sew, cmd_vl, cmd_avg, cmd_vs0, cmd_vs1, cmd_vd,
        input  cmd_ready, rd_valid, rd_addr0, rd_addr1,
        input  dp_valid, dp_sew, dp_opSel, dp_addr, dp_start_idx,
        input  dp_req_start, dp_req_end, dp_be, dp_avg, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_opSel, cmd_sew, cmd_vl, cmd_avg, cmd_vs0, cmd_vs1, cmd_vd,
        output cmd_ready, rd_valid, rd_addr0, rd_addr1,
        output dp_valid, dp_sew, dp_opSel, dp_addr, dp_start_idx,
        output dp_req_start, dp_req_end, dp_be, dp_avg, busy, done
    );

endinterface

// File: rtl/vadd_seq_dly.sv
// Fixed-depth sideband delay line matching the register-file read latency.
module vadd_seq_dly
    import vadd_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  sb_t  i_sb,
    output sb_t  o_sb
);

    sb_t r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_sb;
            for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_sb = r_pipe[DEPTH-1];

endmodule

// File: rtl/vadd_seq.sv
// Vector add/min/max/compare/average command sequencer: splits a command into 64-bit beats.
// Optional feature macro VADD_SEQ_MASK_EN: mask ops (opSel[8]) get packed-bit addressing.
module vadd_seq
    import vadd_seq_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned DP_LAT = DEF_DP_LAT
) (
    input logic       clk,
    input logic       rst,
    vadd_seq_if.slave bus
);

    localparam int unsigned DRAIN_W = $clog2(RD_LAT + DP_LAT + 1);

    state_t                r_state, w_state_nxt;
    cmd_t                  r_cmd, w_cmd;
    logic [VL_WIDTH-1:0]   r_beat, w_beat_nxt;
    logic [DRAIN_W-1:0]    r_drain, w_drain_nxt;
    logic                  w_accept, w_issue;
    logic                  r_last, w_last_nxt;
    logic [VL_WIDTH-1:0]   w_epb, w_elem, w_rem;
    sb_t                   w_sb_nxt, r_sb, w_sb_dp;
    logic                  r_rd_valid;
    logic [ADDR_WIDTH-1:0] r_rd_addr0, r_rd_addr1;
    logic                  r_cmd_ready, r_busy, r_done;

    assign w_accept = (r_state == IDLE) && bus.cmd_valid;

    // Fields of the beat about to be issued come from the live command on accept.
    always_comb begin
        w_cmd = r_cmd;
        if (w_accept) begin
            w_cmd.opsel = bus.cmd_opSel;
            w_cmd.sew   = bus.cmd_sew;
            w_cmd.vl    = bus.cmd_vl;
            w_cmd.avg   = bus.cmd_avg;
            w_cmd.vs0   = bus.cmd_vs0;
            w_cmd.vs1   = bus.cmd_vs1;
            w_cmd.vd    = bus.cmd_vd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_drain_nxt = r_drain;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_vl == '0) begin
                        w_state_nxt = DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_beat_nxt  = '0;
                        w_issue     = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (r_last) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = DRAIN_W'(RD_LAT + DP_LAT);
                end else begin
                    w_beat_nxt = r_beat + VL_WIDTH'(1);
                    w_issue    = 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain == '0) w_state_nxt = IDLE;
                else               w_drain_nxt = r_drain - DRAIN_W'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-beat sideband; everything stays zero on cycles without a beat.
    always_comb begin
        w_epb      = VL_WIDTH'(BE_WIDTH) >> w_cmd.sew;
        w_elem     = w_beat_nxt << (2'd3 - w_cmd.sew);
        w_rem      = w_cmd.vl - w_elem;
        w_last_nxt = w_issue && (w_rem <= w_epb);
        w_sb_nxt   = '0;
        if (w_issue) begin
            w_sb_nxt.valid     = 1'b1;
            w_sb_nxt.sew       = w_cmd.sew;
            w_sb_nxt.opsel     = w_cmd.opsel;
            w_sb_nxt.avg       = w_cmd.avg;
            w_sb_nxt.be        = be_calc(w_rem, w_cmd.sew);
            w_sb_nxt.req_start = (w_beat_nxt == '0);
            w_sb_nxt.req_end   = (w_rem <= w_epb);
            w_sb_nxt.addr      = w_cmd.vd + ADDR_WIDTH'(w_beat_nxt);
            w_sb_nxt.start_idx = '0;
`ifdef VADD_SEQ_MASK_EN
            if (w_cmd.opsel[OPSEL_WIDTH-1]) begin
                w_sb_nxt.start_idx = w_elem[SIDX_WIDTH-1:0];
                w_sb_nxt.addr      = w_cmd.vd + ADDR_WIDTH'(w_elem >> SIDX_WIDTH);
            end
`else
            w_sb_nxt.opsel[OPSEL_WIDTH-1] = 1'b0;
`endif
        end
    end

`ifndef VADD_SEQ_MASK_EN
    logic w_unused_mask_bit;
    assign w_unused_mask_bit = w_cmd.opsel[OPSEL_WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd       <= '0;
            r_beat      <= '0;
            r_drain     <= '0;
            r_last      <= 1'b0;
            r_sb        <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_addr0  <= '0;
            r_rd_addr1  <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) r_cmd <= w_cmd;
            r_beat      <= w_beat_nxt;
            r_drain     <= w_drain_nxt;
            r_last      <= w_last_nxt;
            r_sb        <= w_sb_nxt;
            r_rd_valid  <= w_issue;
            r_rd_addr0  <= w_issue ? w_cmd.vs0 + ADDR_WIDTH'(w_beat_nxt) : '0;
            r_rd_addr1  <= w_issue ? w_cmd.vs1 + ADDR_WIDTH'(w_beat_nxt) : '0;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DRAIN) && (w_drain_nxt == '0);
        end
    end

    vadd_seq_dly #(.DEPTH(RD_LAT)) u_dly (
        .clk   (clk),
        .rst_n (rst),
        .i_sb  (r_sb),
        .o_sb  (w_sb_dp)
    );

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_addr0     = r_rd_addr0;
    assign bus.rd_addr1     = r_rd_addr1;
    assign bus.dp_valid     = w_sb_dp.valid;
    assign bus.dp_sew       = w_sb_dp.sew;
    assign bus.dp_opSel     = w_sb_dp.opsel;
    assign bus.dp_addr      = w_sb_dp.addr;
    assign bus.dp_start_idx = w_sb_dp.start_idx;
    assign bus.dp_req_start = w_sb_dp.req_start;
    assign bus.dp_req_end   = w_sb_dp.req_end;
    assign bus.dp_be        = w_sb_dp.be;
    assign bus.dp_avg       = w_sb_dp.avg;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule

// File: tb/tb_vadd_seq.sv
// Self-checking bench for vadd_seq: directed and random commands against a beat-list model.
module tb_vadd_seq;
    import vadd_seq_pkg::*;

    localparam int RL = int'(DEF_RD_LAT);
    localparam int DL = int'(DEF_DP_LAT);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vadd_seq_if bus ();

    vadd_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  sidx;
        logic        rs;
        logic        re;
        logic [7:0]  be;
    } beat_t;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one command at the current negedge and checks every following cycle.
    task automatic run_cmd(input logic [8:0] op, input logic [1:0] sew, input int vl,
                           input logic avg, input logic [31:0] vs0, input logic [31:0] vs1,
                           input logic [31:0] vd, input bit hold, input int abort_k);
        int          epb, nb, done_k, last_k, bytes, elem, rem, j;
        beat_t       q[$];
        beat_t       bt;
        logic [8:0]  opx;
        logic [127:0] exp_v;
        epb = 8 >> sew;
        nb  = (vl + epb - 1) / epb;
        for (int b = 0; b < nb; b++) begin
            elem  = b * epb;
            rem   = vl - elem;
            bytes = ((rem >= epb) ? epb : rem) * (1 << sew);
            bt.be = 8'((1 << bytes) - 1);
            bt.rs = (b == 0);
            bt.re = (b == nb - 1);
            bt.addr = 32'(vd + 32'(b));
            bt.sidx = 6'd0;
`ifdef VADD_SEQ_MASK_EN
            if (op[8]) begin
                bt.addr = 32'(vd + 32'(elem / 64));
                bt.sidx = 6'(elem % 64);
            end
`endif
            q.push_back(bt);
        end
`ifdef VADD_SEQ_MASK_EN
        opx = op;
`else
        opx = op & 9'h0FF;
`endif
        done_k = (nb == 0) ? 1 : nb + RL + DL + 1;
        last_k = (abort_k != 0) ? abort_k : done_k + 1;

        bus.cmd_valid = 1'b1;
        bus.cmd_opSel = op;
        bus.cmd_sew   = sew;
        bus.cmd_vl    = 11'(vl);
        bus.cmd_avg   = avg;
        bus.cmd_vs0   = vs0;
        bus.cmd_vs1   = vs1;
        bus.cmd_vd    = vd;
        chk("ready_at_offer", 128'(bus.cmd_ready), 128'(1'b1));

        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (!hold) bus.cmd_valid = 1'b0;
            exp_v = '0;
            if (k <= nb) exp_v = 128'({1'b1, 32'(vs0 + 32'(k - 1)), 32'(vs1 + 32'(k - 1))});
            chk("rd", 128'({bus.rd_valid, bus.rd_addr0, bus.rd_addr1}), exp_v);
            j = k - 1 - RL;
            exp_v = '0;
            if (j >= 0 && j < nb)
                exp_v = 128'({1'b1, sew, opx, q[j].addr, q[j].sidx, q[j].rs, q[j].re, q[j].be, avg});
            chk("dp", 128'({bus.dp_valid, bus.dp_sew, bus.dp_opSel, bus.dp_addr, bus.dp_start_idx,
                            bus.dp_req_start, bus.dp_req_end, bus.dp_be, bus.dp_avg}), exp_v);
            chk("done",  128'(bus.done),      128'(k == done_k));
            chk("busy",  128'(bus.busy),      128'(k <= done_k));
            chk("ready", 128'(bus.cmd_ready), 128'(k > done_k));
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, 128'({bus.cmd_ready, bus.rd_valid, bus.dp_valid, bus.busy, bus.done}),
                128'(5'b10000));
        end
    endtask

    initial begin
        int g, vl_r;
        bus.cmd_valid = 1'b0;
        bus.cmd_opSel = '0;
        bus.cmd_sew   = '0;
        bus.cmd_vl    = '0;
        bus.cmd_avg   = 1'b0;
        bus.cmd_vs0   = '0;
        bus.cmd_vs1   = '0;
        bus.cmd_vd    = '0;

        repeat (3) @(negedge clk);
        chk("rst_hold_outputs", 128'({bus.rd_valid, bus.dp_valid, bus.busy, bus.done}), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 128'(bus.cmd_ready), 128'(1'b1));
        chk("rst_release_zero", 128'({bus.rd_valid, bus.rd_addr0, bus.rd_addr1, bus.dp_valid,
                                      bus.dp_addr, bus.dp_be, bus.busy, bus.done}), 128'(0));

        // Directed cases.
        run_cmd(9'h012, 2'd0, 16, 1'b0, 32'h10, 32'h20, 32'h30, 1'b0, 0);
        idle_check(2, "gap");
        run_cmd(9'h005, 2'd2, 5, 1'b1, 32'h100, 32'h200, 32'h300, 1'b0, 0);
        run_cmd(9'h033, 2'd1, 0, 1'b0, 32'h1, 32'h2, 32'h3, 1'b0, 0);
        idle_check(1, "after_vl0");
        run_cmd(9'h100, 2'd0, 72, 1'b0, 32'h40, 32'h80, 32'h500, 1'b0, 0);
        run_cmd(9'h1A5, 2'd3, 3, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_cmd(9'h007, 2'd0, 2047, 1'b0, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0);
        run_cmd(9'h1FF, 2'd1, 1, 1'b1, 32'h7, 32'h8, 32'h9, 1'b0, 0);

        // Held cmd_valid: the same command is taken again only after done.
        run_cmd(9'h021, 2'd1, 9, 1'b0, 32'hA0, 32'hB0, 32'hC0, 1'b1, 0);
        run_cmd(9'h021, 2'd1, 9, 1'b0, 32'hA0, 32'hB0, 32'hC0, 1'b0, 0);

        // Random commands, some back-to-back.
        for (int i = 0; i < 30; i++) begin
            vl_r = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 80));
            run_cmd(9'($urandom), 2'($urandom_range(0, 3)), vl_r, 1'($urandom),
                    $urandom, $urandom, $urandom, 1'b0, 0);
            g = int'($urandom_range(0, 2));
            if (g > 0) idle_check(g, "rand_gap");
        end

        // Reset while beats are in flight.
        run_cmd(9'h011, 2'd0, 64, 1'b1, 32'h600, 32'h700, 32'h800, 1'b0, 3);
        #1 rst = 1'b0;
        #1;
        chk("midrst_outputs", 128'({bus.rd_valid, bus.dp_valid, bus.busy, bus.done}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_check(15, "post_rst");
        run_cmd(9'h002, 2'd2, 6, 1'b0, 32'h11, 32'h22, 32'h33, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
